mux_stream_nto1: RTL
====================

Name: mux_stream_nto1

Overview:
Parametrised N-channel, W-bit stream multiplexer with a registered output and a valid/ready handshake on every port. It supports two modes: fixed select, driven by a sel port, and round-robin arbitration across the valid channels. It sits between multiple producer channels and a single downstream consumer. It replaces the plain combinational select mux wherever back-pressure or fair sharing is needed.

Parameters:
N_CH, 8, number of input channels (>=2)
W, 8, data width per channel
SEL_W, $clog2(N_CH), width of sel and out_ch
CNT_W, 16, width of the transfer counter

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  reset, asynchronous and active-low
in_data  input  N_CH*W  channel i occupies bits [i*W +: W]
in_valid  input  N_CH  per-channel valid
in_ready  output  N_CH  per-channel ready
sel  input  SEL_W  channel select, used in fixed mode
mode  input  1  0 = fixed select, 1 = round-robin
out_data  output  W  registered output data
out_ch  output  SEL_W  source channel of out_data
out_valid  output  1  output valid
out_ready  input  1  downstream ready
xfer_cnt  output  CNT_W  count of completed output transfers

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_ch=0, xfer_cnt=0, rr_ptr=0. in_ready is combinational and is therefore all-zero while out_valid is held 0 by reset and there is no grant.
- load_en = !out_valid || out_ready. The output register accepts new data only when it is empty or is being drained in the same cycle. Full throughput is 1 word/cycle.
- Grant, fixed mode:
  - g=sel and granted = (sel < N_CH) && in_valid[sel].
  - sel >= N_CH: no grant and all in_ready=0. This replaces the old default-zero behaviour; no spurious data is produced.
- Grant, round-robin mode:
  - g = first i with in_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... with wrap mod N_CH.
  - granted = |in_valid.
- in_ready[i] = load_en && granted && (g==i). At most one in_ready is high per cycle. in_ready never depends on in_valid of other channels in fixed mode.
- Input transfer on channel g when in_valid[g] && in_ready[g]. Next cycle: out_data = that channel's word, out_ch=g, out_valid=1. Latency is 1 cycle.
- Output transfer when out_valid && out_ready: xfer_cnt increments, wrapping at 2^CNT_W.
  - If no new input transfers in the same cycle, out_valid falls to 0 next cycle.
  - Simultaneous output drain and input load: out_valid stays 1 and the data is replaced.
- Stall (out_valid && !out_ready): out_data and out_ch are held stable and all in_ready=0.
- rr_ptr updates only on an input transfer in round-robin mode: rr_ptr <= (g+1) mod N_CH, wrapping from N_CH-1 to 0. In fixed mode rr_ptr holds.
- mode or sel changes take effect at the next grant evaluation. A word already held in the output register is unaffected.
- Reset asserted mid-transfer: the held word is discarded and everything returns to reset values immediately.

Decomposition:
- Shared package mux_pkg:
  - MODE_FIXED=1'b0, MODE_RR=1'b1
  - the function for clog2 width, if not a built-in
- Sub-module rr_pick: combinational rotate-priority picker.
  - Inputs: req[N_CH], ptr[SEL_W].
  - Outputs: gnt_idx[SEL_W], any.
  - Reusable by later arbiters.

Test Plan:
- Reset release with all in_valid=1, mode=0, sel=2, out_ready=1. The cycle after the first edge gives out_data=ch2 word, out_ch=2, out_valid=1. Only in_ready[2] is ever high.
- Fixed mode, sel=5 with in_valid[5]=0 for 3 cycles. Required response: in_ready=0 and out_valid=0 throughout. When in_valid[5] rises, out_valid=1 one cycle later.
- Round-robin, in_valid=8'b1010_0101, out_ready=1, 8 cycles. Required out_ch sequence: 0,2,5,7,0,2,5,7. xfer_cnt ends at 8.
- Back-pressure: out_ready=0 for 4 cycles after out_valid=1. Required response: out_data and out_ch stable and in_ready=0. On out_ready=1 the next word loads in the same cycle, out_valid stays 1, and xfer_cnt increments by 1.
- Counter wrap: CNT_W=4 with 17 transfers. Required: xfer_cnt=1.
- rst_n pulled low while out_valid=1. Required: out_valid=0 asynchronously (before the next edge), rr_ptr=0, and the first round-robin grant after release goes to the lowest valid channel.

Source files
------------

// File: rtl/mux_pkg.sv
// mux_pkg
// Shared definitions for the stream multiplexer family.
//   MODE_FIXED / MODE_RR : encodings of the mode input
//   idx_width()          : index width for an n-entry vector, never below 1
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Same result as $clog2 for n >= 2.
  // Clamped to 1 so a degenerate one-entry vector still gets a usable index.
  function automatic int idx_width(input int n);
    int w;
    w = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational rotate-priority picker. Starting at ptr and wrapping modulo
// N_CH, it returns the index of the first asserted request.
// Ports:
//   req     [N_CH]  request vector
//   ptr     [SEL_W] highest-priority position for this evaluation
//   gnt_idx [SEL_W] index of the winning request (0 when none)
//   any             at least one request is asserted
module rr_pick
  import mux_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int SEL_W = idx_width(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  // The scan runs from the farthest offset down to offset 0, so the last
  // hit written is the one closest to ptr. This avoids an early-exit loop.
  // ptr is reduced modulo N_CH so that a non-power-of-two N_CH still works.
  always_comb begin
    int base;
    int c;
    gnt_idx = '0;
    base    = int'(ptr) % N_CH;
    c       = 0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      c = (base + k) % N_CH;
      if (req[c]) gnt_idx = SEL_W'(c);
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux_stream_nto1.sv
// mux_stream_nto1
// N-channel, W-bit stream multiplexer with a registered output. Every port
// uses a valid/ready handshake. The mode input selects between a fixed
// channel (sel) and round-robin arbitration across the valid channels.
// Ports:
//   clk, rst_n           clock (rising edge); asynchronous active-low reset
//   in_data  [N_CH*W]    channel i occupies bits [i*W +: W]
//   in_valid [N_CH]      per-channel valid
//   in_ready [N_CH]      per-channel ready (combinational, one-hot or zero)
//   sel      [SEL_W]     channel select used in fixed mode
//   mode                 0 = fixed select, 1 = round-robin
//   out_data [W]         registered output word
//   out_ch   [SEL_W]     source channel of out_data
//   out_valid/out_ready  output handshake
//   xfer_cnt [CNT_W]     completed output transfers, wraps
module mux_stream_nto1
  import mux_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int W     = 8,
  parameter int SEL_W = idx_width(N_CH),
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] in_data,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ready,
  input  logic [SEL_W-1:0]  sel,
  input  logic              mode,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_ch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  xfer_cnt
);

  logic             load_en;
  logic             granted;
  logic             in_xfer;
  logic             out_xfer;
  logic             sel_ok;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_any;
  logic [SEL_W-1:0] rr_ptr;
  logic [W-1:0]     grant_data;

  rr_pick #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt_idx (rr_idx),
    .any     (rr_any)
  );

  // The output register can take a word when it is empty or is being
  // drained in the same cycle. The rst_n term keeps every in_ready low while
  // reset is held. A producer therefore never sees a handshake whose word
  // the reset would discard.
  assign load_en  = rst_n && (!out_valid || out_ready);
  assign out_xfer = out_valid && out_ready;

  // An out-of-range sel never grants. No word is produced in that case.
  assign sel_ok = (int'(sel) < N_CH);

  // Grant selection. In fixed mode the grant depends only on the selected
  // channel's own valid. In round-robin mode the picker decides.
  always_comb begin
    grant_idx = '0;
    granted   = 1'b0;
    if (mode == MODE_RR) begin
      grant_idx = rr_idx;
      granted   = rr_any;
    end else begin
      grant_idx = sel;
      if (sel_ok) granted = in_valid[sel];
    end
  end

  // A grant implies that the granted channel is valid. The input transfer
  // therefore reduces to a grant in a cycle where the register can load.
  assign in_xfer = load_en && granted;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N_CH; i++) begin
      in_ready[i] = in_xfer && (int'(grant_idx) == i);
    end
  end

  // The loop-based data select never indexes past the end of in_data,
  // even when an out-of-range sel is present.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (int'(grant_idx) == i) grant_data = in_data[i*W +: W];
    end
  end

  // Output register. A load always wins, which covers the case of a drain
  // and a reload in the same cycle. Otherwise a drain empties the register.
  // During a stall nothing loads, so data and channel hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else begin
      if (in_xfer) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_ch    <= grant_idx;
      end else if (out_xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Completed downstream transfers. The counter wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (out_xfer) begin
      xfer_cnt <= xfer_cnt + CNT_W'(1);
    end
  end

  // The round-robin pointer moves just past the last winner. It moves only
  // when a round-robin grant is actually taken, so fixed-mode traffic leaves
  // the fairness position untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (in_xfer && (mode == MODE_RR)) begin
      if (int'(grant_idx) == N_CH - 1) rr_ptr <= '0;
      else                             rr_ptr <= grant_idx + SEL_W'(1);
    end
  end

endmodule
